pipelined_adder: RTL and testbench

- Parametrised, pipelined carry-propagate adder/subtractor. Generalises the single-bit full adder to WIDTH bits.
- Operands are split into STAGES equal chunks. Each pipeline stage adds one chunk and registers the carry into the next stage.
- Valid/ready streaming handshake with full backpressure; one result per cycle at full throughput.
- Used as the datapath adder in the ALU/accumulator path, where a single-cycle WIDTH-bit ripple misses timing.

---
 rtl/pipelined_adder.sv | 123 ++++++++++++
 tb/tb_pipelined_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined carry-propagate adder/subtractor.
// The operands are cut into STAGES chunks of CW bits. Stage k adds chunk k and
// registers the carry, the partial sum and the operand chunks still to be added.
// Each stage has a valid bit and a skid-free ready chain, so the pipeline
// sustains one result per cycle and collapses bubbles under backpressure.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow
);
    localparam int CW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: STAGES must be in 1..WIDTH and divide WIDTH");
    end

    genvar gi;
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
        // Sum bits already produced once this stage has run, and operand bits
        // still arriving at this stage (chunk gi and everything above it).
        localparam int LO_W = (gi + 1) * CW;
        localparam int IN_W = WIDTH - gi * CW;

        logic            ready;
        logic            valid_reg;
        logic            carry_reg;
        logic [LO_W-1:0] sum_reg;

        logic            src_valid;
        logic            src_carry;
        logic [IN_W-1:0] src_a;
        logic [IN_W-1:0] src_b;
        logic [CW:0]     chunk_sum;
        logic [LO_W-1:0] sum_next;

        if (gi == 0) begin : g_src
            // First stage works straight from the ports; subtraction is a + ~b + 1.
            assign src_valid = in_valid;
            assign src_a     = a;
            assign src_b     = sub ? ~b : b;
            assign src_carry = sub | cin;
            assign sum_next  = chunk_sum[CW-1:0];
        end else begin : g_src
            assign src_valid = g_stage[gi-1].valid_reg;
            assign src_a     = g_stage[gi-1].g_ops.a_reg;
            assign src_b     = g_stage[gi-1].g_ops.b_reg;
            assign src_carry = g_stage[gi-1].carry_reg;
            assign sum_next  = {chunk_sum[CW-1:0], g_stage[gi-1].sum_reg};
        end

        // The low chunk of the remaining operands is always the one this stage adds.
        assign chunk_sum = {1'b0, src_a[CW-1:0]} + {1'b0, src_b[CW-1:0]}
                         + {{CW{1'b0}}, src_carry};

        // Stage register: advances only when this stage is ready, otherwise holds.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                valid_reg <= 1'b0;
                carry_reg <= 1'b0;
                sum_reg   <= '0;
            end else if (ready) begin
                valid_reg <= src_valid;
                if (src_valid) begin
                    carry_reg <= chunk_sum[CW];
                    sum_reg   <= sum_next;
                end
            end
        end

        if (gi < STAGES - 1) begin : g_ops
            logic [IN_W-CW-1:0] a_reg;
            logic [IN_W-CW-1:0] b_reg;

            // An empty stage accepts even if everything downstream is stalled.
            assign ready = !valid_reg || g_stage[gi+1].ready;

            // Carry the not-yet-added operand chunks along with the partial sum.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    a_reg <= '0;
                    b_reg <= '0;
                end else if (ready && src_valid) begin
                    a_reg <= src_a[IN_W-1:CW];
                    b_reg <= src_b[IN_W-1:CW];
                end
            end
        end else begin : g_tail
            logic ovf_reg;

            assign ready = out_ready || !valid_reg;

            // Overflow = carry into MSB xor carry out; the carry into the MSB is
            // recovered from the MSB operand bits and the MSB sum bit.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ovf_reg <= 1'b0;
                end else if (ready && src_valid) begin
                    ovf_reg <= src_a[CW-1] ^ src_b[CW-1] ^ chunk_sum[CW-1] ^ chunk_sum[CW];
                end
            end
        end
    end

    assign in_ready  = g_stage[0].ready;
    assign out_valid = g_stage[STAGES-1].valid_reg;
    assign s         = g_stage[STAGES-1].sum_reg;
    assign cout      = g_stage[STAGES-1].carry_reg;
    assign overflow  = g_stage[STAGES-1].g_tail.ovf_reg;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: three instances (STAGES = 4, 1, 32) share
// operands; directed vectors run on all three, streaming/backpressure/reset
// scenarios run on the STAGES=4 instance.
module tb_pipelined_adder;
    logic        clk;
    logic        reset_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        iv   [3];
    logic        ordy [3];
    logic        ir   [3];
    logic        ov   [3];
    logic [31:0] sv   [3];
    logic        co   [3];
    logic        of   [3];

    int total = 0;
    int bad   = 0;
    int lat [3] = '{4, 1, 32};

    logic [33:0] exp_q [$];
    logic [31:0] st_a   [32];
    logic [31:0] st_b   [32];
    logic        st_cin [32];
    logic        st_sub [32];

    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_s4 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[0]), .out_ready(ordy[0]),
        .s(sv[0]), .cout(co[0]), .overflow(of[0]));

    pipelined_adder #(.WIDTH(32), .STAGES(1)) u_s1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[1]), .out_ready(ordy[1]),
        .s(sv[1]), .cout(co[1]), .overflow(of[1]));

    pipelined_adder #(.WIDTH(32), .STAGES(32)) u_s32 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov[2]), .out_ready(ordy[2]),
        .s(sv[2]), .cout(co[2]), .overflow(of[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-width add with signed overflow from the sign rule.
    function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mcin, input logic msub);
        logic [31:0] eb;
        logic [32:0] full;
        logic        ovf;
        eb   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, eb} + {32'd0, (msub ? 1'b1 : mcin)};
        ovf  = (ma[31] == eb[31]) && (full[31] != ma[31]);
        return {ovf, full};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One transfer into all three instances; checks the exact latency of each.
    task automatic directed(input logic [31:0] va, input logic [31:0] vb, input logic vcin,
                            input logic vsub, input logic [31:0] es, input logic ec,
                            input logic eo, input string tag);
        a = va; b = vb; cin = vcin; sub = vsub;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b1;
            ordy[d] = 1'b1;
        end
        #1;
        for (int d = 0; d < 3; d++) chk($sformatf("%s/S%0d in_ready", tag, lat[d]), ir[d], 1);
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) iv[d] = 1'b0;
        for (int k = 0; k <= 32; k++) begin
            for (int d = 0; d < 3; d++) begin
                if (k == lat[d] - 1) begin
                    chk($sformatf("%s/S%0d valid", tag, lat[d]), ov[d], 1);
                    chk($sformatf("%s/S%0d s", tag, lat[d]), sv[d], es);
                    chk($sformatf("%s/S%0d cout", tag, lat[d]), co[d], ec);
                    chk($sformatf("%s/S%0d ovf", tag, lat[d]), of[d], eo);
                end else if (k == lat[d] || k == lat[d] - 2) begin
                    chk($sformatf("%s/S%0d idle k=%0d", tag, lat[d], k), ov[d], 0);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Streams n operands from st_* into the STAGES=4 instance, optionally
    // holding out_ready low for stall_len cycles starting at cycle stall_at.
    task automatic stream(input int n, input int stall_at, input int stall_len, input string tag);
        int          sent  = 0;
        int          got   = 0;
        int          cyc   = 0;
        int          first = -1;
        int          last  = -1;
        logic [31:0] held_s = '0;
        logic [33:0] e;
        bit          stalled;
        while ((sent < n || got < n) && cyc < n + stall_len + 40) begin
            stalled = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            ordy[0] = !stalled;
            iv[0]   = (sent < n);
            if (sent < n) begin
                a = st_a[sent]; b = st_b[sent]; cin = st_cin[sent]; sub = st_sub[sent];
            end
            #1;
            if (stalled) begin
                if (cyc == stall_at) begin
                    chk($sformatf("%s stall valid", tag), ov[0], 1);
                    held_s = sv[0];
                end else begin
                    chk($sformatf("%s stall hold c%0d", tag, cyc), sv[0], held_s);
                end
                if (cyc == stall_at + stall_len - 1) begin
                    chk($sformatf("%s full in_ready", tag), ir[0], 0);
                    chk($sformatf("%s held count", tag), exp_q.size(), 4);
                end
            end else if (stall_len == 0 && sent < n) begin
                chk($sformatf("%s in_ready c%0d", tag, cyc), ir[0], 1);
            end
            if (ov[0] && ordy[0]) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("%s extra output", tag), 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s #%0d s", tag, got), sv[0], e[31:0]);
                    chk($sformatf("%s #%0d cout", tag, got), co[0], e[32]);
                    chk($sformatf("%s #%0d ovf", tag, got), of[0], e[33]);
                end
                got++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (iv[0] && ir[0]) begin
                exp_q.push_back(model(a, b, cin, sub));
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        iv[0] = 1'b0;
        chk($sformatf("%s delivered", tag), got, n);
        chk($sformatf("%s leftover", tag), exp_q.size(), 0);
        if (stall_len == 0) chk($sformatf("%s consecutive", tag), last - first, n - 1);
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            ordy[d] = 1'b1;
        end
        #12;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset/S%0d valid", lat[d]), ov[d], 0);
            chk($sformatf("reset/S%0d s", lat[d]), sv[d], 0);
            chk($sformatf("reset/S%0d cout", lat[d]), co[d], 0);
            chk($sformatf("reset/S%0d ovf", lat[d]), of[d], 0);
            chk($sformatf("reset/S%0d in_ready", lat[d]), ir[d], 1);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;

        directed(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "allones+1");
        directed(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "0-1");
        directed(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "min-1");
        directed(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "max+1");
        directed(32'h0001_0000, 32'h0000_FFFF, 1'b1, 1'b0, 32'h0002_0000, 1'b0, 1'b0, "chunkcarry");
        directed(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "x-x");
        directed(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 1'b0, "1+1+cin");

        for (int i = 0; i < 32; i++) begin
            st_a[i]   = $urandom;
            st_b[i]   = $urandom;
            st_cin[i] = 1'($urandom_range(0, 1));
            st_sub[i] = 1'($urandom_range(0, 1));
        end
        stream(16, 0, 0, "throughput");
        stream(14, 5, 6, "backpressure");

        // Three transfers in flight behind a stalled output, then async reset.
        ordy[0] = 1'b0;
        sub = 1'b0; cin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 32'hFFFF_FFFF; b = 32'd2 + 32'(i);
            iv[0] = 1'b1;
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset valid", ov[0], 1);
        chk("pre-reset s", sv[0], 32'h0000_0001);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async reset valid", ov[0], 0);
        chk("async reset s", sv[0], 0);
        chk("async reset cout", co[0], 0);
        chk("async reset in_ready", ir[0], 1);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        st_a[0] = 32'd5; st_b[0] = 32'd6; st_cin[0] = 1'b0; st_sub[0] = 1'b0;
        stream(1, 0, 0, "post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
